// File: rtl/mem_bus_interconnect_pkg.sv
// Shared widths, defaults and FSM state type for the CPU-to-slave memory interconnect.
package mem_bus_interconnect_pkg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int STRB_W = DATA_W / 8;
    localparam logic [DATA_W-1:0] DEFAULT_ERR_RDATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/mem_bus_interconnect_if.sv
// CPU native memory port plus the broadcast slave channel it is decoded onto.
interface mem_bus_interconnect_if
    import mem_bus_interconnect_pkg::*;
#(
    parameter int NUM_SLAVES = 2
);
    logic                         m_valid;
    logic [ADDR_W-1:0]            m_addr;
    logic [DATA_W-1:0]            m_wdata;
    logic [STRB_W-1:0]            m_wstrb;
    logic                         m_ready;
    logic [DATA_W-1:0]            m_rdata;
    logic                         m_error;

    logic [NUM_SLAVES-1:0]        s_sel;
    logic [ADDR_W-1:0]            s_addr;
    logic [DATA_W-1:0]            s_wdata;
    logic [STRB_W-1:0]            s_wstrb;
    logic [NUM_SLAVES-1:0]        s_ready;
    logic [DATA_W*NUM_SLAVES-1:0] s_rdata;

    // The interconnect is the slave of the CPU and drives the slave channel.
    modport slave (
        input  m_valid, m_addr, m_wdata, m_wstrb, s_ready, s_rdata,
        output m_ready, m_rdata, m_error, s_sel, s_addr, s_wdata, s_wstrb
    );

    modport master (
        output m_valid, m_addr, m_wdata, m_wstrb, s_ready, s_rdata,
        input  m_ready, m_rdata, m_error, s_sel, s_addr, s_wdata, s_wstrb
    );
endinterface

// File: rtl/mem_bus_interconnect_addr_decoder.sv
// Combinational base/mask window decode; the lowest-numbered matching window wins.
module mem_bus_interconnect_addr_decoder
    import mem_bus_interconnect_pkg::*;
#(
    parameter int                           NUM_SLAVES = 2,
    parameter logic [ADDR_W*NUM_SLAVES-1:0] SLAVE_BASE = {32'h8000_0000, 32'h0000_0000},
    parameter logic [ADDR_W*NUM_SLAVES-1:0] SLAVE_MASK = {32'hFFFF_FFFF, 32'hFFFF_E000},
    parameter int                           IDX_W      = idx_width(NUM_SLAVES)
) (
    input  logic [ADDR_W-1:0]     addr,
    output logic                  hit,
    output logic [NUM_SLAVES-1:0] onehot,
    output logic [IDX_W-1:0]      idx
);
    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves one unassigned (no latch).
        hit = 1'b0;
        idx = '0;
        // Scanning downwards lets the lowest matching index overwrite any higher one.
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((addr & SLAVE_MASK[ADDR_W*i +: ADDR_W]) == SLAVE_BASE[ADDR_W*i +: ADDR_W]) begin
                hit = 1'b1;
                idx = IDX_W'(i);
            end
        end
        onehot = hit ? (NUM_SLAVES'(1) << idx) : '0;
    end
endmodule

// File: rtl/mem_bus_interconnect.sv
// Registered picorv32-to-slaves interconnect with unmapped-address and timeout error responses.
module mem_bus_interconnect
    import mem_bus_interconnect_pkg::*;
#(
    parameter int                           NUM_SLAVES     = 2,
    parameter logic [ADDR_W*NUM_SLAVES-1:0] SLAVE_BASE     = {32'h8000_0000, 32'h0000_0000},
    parameter logic [ADDR_W*NUM_SLAVES-1:0] SLAVE_MASK     = {32'hFFFF_FFFF, 32'hFFFF_E000},
    parameter int                           TIMEOUT_CYCLES = 255,
    parameter logic [DATA_W-1:0]            ERR_RDATA      = DEFAULT_ERR_RDATA
) (
    input  logic                  clk,
    input  logic                  reset,
    mem_bus_interconnect_if.slave bus,
    output logic [ADDR_W-1:0]     err_addr,
    output logic [7:0]            err_count
);
    localparam int               IDX_W    = idx_width(NUM_SLAVES);
    localparam int               TMR_W    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    state_e                state_q,     state_d;
    logic [NUM_SLAVES-1:0] sel_q,       sel_d;
    logic [IDX_W-1:0]      idx_q,       idx_d;
    logic [ADDR_W-1:0]     addr_q,      addr_d;
    logic [DATA_W-1:0]     wdata_q,     wdata_d;
    logic [STRB_W-1:0]     wstrb_q,     wstrb_d;
    logic [TMR_W-1:0]      timer_q,     timer_d;
    logic [DATA_W-1:0]     rdata_q,     rdata_d;
    logic                  ready_q,     ready_d;
    logic                  error_q,     error_d;
    logic                  skip_q,      skip_d;
    logic [ADDR_W-1:0]     err_addr_q,  err_addr_d;
    logic [7:0]            err_count_q, err_count_d;

    logic                  err_evt;
    logic                  dec_hit;
    logic [NUM_SLAVES-1:0] dec_onehot;
    logic [IDX_W-1:0]      dec_idx;

    mem_bus_interconnect_addr_decoder #(
        .NUM_SLAVES (NUM_SLAVES),
        .SLAVE_BASE (SLAVE_BASE),
        .SLAVE_MASK (SLAVE_MASK),
        .IDX_W      (IDX_W)
    ) u_decoder (
        .addr   (bus.m_addr),
        .hit    (dec_hit),
        .onehot (dec_onehot),
        .idx    (dec_idx)
    );

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        idx_d       = idx_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        timer_d     = timer_q;
        rdata_d     = rdata_q;
        ready_d     = 1'b0;
        error_d     = 1'b0;
        skip_d      = 1'b0;
        err_addr_d  = err_addr_q;
        err_count_d = err_count_q;
        err_evt     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // The CPU may still hold valid in the cycle right after a response.
                if (bus.m_valid && !skip_q) begin
                    addr_d  = bus.m_addr;
                    wdata_d = bus.m_wdata;
                    wstrb_d = bus.m_wstrb;
                    timer_d = '0;
                    if (dec_hit) begin
                        idx_d   = dec_idx;
                        sel_d   = dec_onehot;
                        state_d = ST_ACCESS;
                    end else begin
                        ready_d = 1'b1;
                        error_d = 1'b1;
                        rdata_d = ERR_RDATA;
                        err_evt = 1'b1;
                        state_d = ST_RESP;
                    end
                end
            end
            ST_ACCESS: begin
                // A ready arriving in the final timeout cycle takes priority over the error.
                if (bus.s_ready[idx_q]) begin
                    rdata_d = bus.s_rdata[DATA_W*idx_q +: DATA_W];
                    ready_d = 1'b1;
                    sel_d   = '0;
                    state_d = ST_RESP;
                end else if ((TIMEOUT_CYCLES != 0) && (timer_q == TMR_LAST)) begin
                    ready_d = 1'b1;
                    error_d = 1'b1;
                    rdata_d = ERR_RDATA;
                    sel_d   = '0;
                    err_evt = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_RESP: begin
                skip_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (err_evt) begin
            err_addr_d = addr_d;
            if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            sel_q       <= '0;
            idx_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            timer_q     <= '0;
            rdata_q     <= '0;
            ready_q     <= 1'b0;
            error_q     <= 1'b0;
            skip_q      <= 1'b0;
            err_addr_q  <= '0;
            err_count_q <= '0;
        end else begin
            // NOTE: non-blocking updates so every flop samples the pre-edge values of the others.
            state_q     <= state_d;
            sel_q       <= sel_d;
            idx_q       <= idx_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            timer_q     <= timer_d;
            rdata_q     <= rdata_d;
            ready_q     <= ready_d;
            error_q     <= error_d;
            skip_q      <= skip_d;
            err_addr_q  <= err_addr_d;
            err_count_q <= err_count_d;
        end
    end

    assign bus.m_ready = ready_q;
    assign bus.m_rdata = rdata_q;
    assign bus.m_error = error_q;
    assign bus.s_sel   = sel_q;
    assign bus.s_addr  = addr_q;
    assign bus.s_wdata = wdata_q;
    assign bus.s_wstrb = wstrb_q;
    assign err_addr    = err_addr_q;
    assign err_count   = err_count_q;
endmodule

// File: tb/tb_mem_bus_interconnect.sv
// Randomised scoreboard bench: a driver plans each access, a slave model responds, a monitor checks m_ready.
`timescale 1ns/1ps
module tb_mem_bus_interconnect;
    localparam int          N        = 2;
    localparam int          TIMEOUT  = 255;
    localparam logic [31:0] ERR_WORD = 32'hDEAD_BEEF;
    localparam int          NEVER    = 100000;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] err_addr;
    logic [7:0]  err_count;
    int          cyc         = 0;
    int          vectors     = 0;
    int          miscompares = 0;

    // Software view of the map: slave 0 is an 8 KiB SRAM at 0, slave 1 is the LED word.
    logic [31:0] win_base [N] = '{32'h0000_0000, 32'h8000_0000};
    logic [31:0] win_mask [N] = '{32'hFFFF_E000, 32'hFFFF_FFFF};
    logic [31:0] edge_addr [4] = '{32'h0000_1FFC, 32'h0000_2000, 32'h8000_0004, 32'h7FFF_FFFC};

    typedef struct {
        int          issue_cyc;
        int          latency;
        bit          chk_rdata;
        logic [31:0] rdata;
        logic        error;
        logic [31:0] err_addr;
        logic [7:0]  err_count;
    } exp_t;
    exp_t sb_q[$];

    logic [N-1:0] cur_sel   = '0;
    logic [31:0]  cur_addr  = '0;
    logic [31:0]  cur_wdata = '0;
    logic [3:0]   cur_wstrb = '0;
    int           plan_lat  = NEVER;
    logic [31:0]  plan_rdata = '0;

    int           model_err_count = 0;
    logic [31:0]  model_err_addr  = '0;

    mem_bus_interconnect_if #(.NUM_SLAVES(N)) bus ();

    mem_bus_interconnect #(
        .NUM_SLAVES     (N),
        .SLAVE_BASE     ({32'h8000_0000, 32'h0000_0000}),
        .SLAVE_MASK     ({32'hFFFF_FFFF, 32'hFFFF_E000}),
        .TIMEOUT_CYCLES (TIMEOUT),
        .ERR_RDATA      (ERR_WORD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .err_addr  (err_addr),
        .err_count (err_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    function automatic int ref_decode(input logic [31:0] a);
        for (int i = 0; i < N; i++) begin
            if ((a & win_mask[i]) == win_base[i]) return i;
        end
        return -1;
    endfunction

    // Monitor: every m_ready pulse must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && bus.m_ready === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_m_ready", 32'(bus.m_ready), 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("latency", 32'(cyc - e.issue_cyc), 32'(e.latency));
                    check("m_error", 32'(bus.m_error), 32'(e.error));
                    if (e.chk_rdata) check("m_rdata", bus.m_rdata, e.rdata);
                    check("err_addr", err_addr, e.err_addr);
                    check("err_count", 32'(err_count), 32'(e.err_count));
                end
            end
        end
    end

    // Slave model: the selected slave answers after plan_lat selected cycles; idle lanes carry noise.
    initial begin
        int n;
        n = 0;
        bus.s_ready = '0;
        bus.s_rdata = '0;
        forever begin
            @(negedge clk);
            if (bus.s_sel !== '0) begin
                n++;
                check("s_sel", 32'(bus.s_sel), 32'(cur_sel));
                if (n == 1) begin
                    check("s_addr", bus.s_addr, cur_addr);
                    check("s_wdata", bus.s_wdata, cur_wdata);
                    check("s_wstrb", 32'(bus.s_wstrb), 32'(cur_wstrb));
                end
            end else begin
                n = 0;
            end
            for (int i = 0; i < N; i++) begin
                if (bus.s_sel[i] === 1'b1) begin
                    bus.s_ready[i]          = (n == plan_lat);
                    bus.s_rdata[32*i +: 32] = plan_rdata;
                end else begin
                    bus.s_ready[i]          = 1'($urandom_range(0, 1));
                    bus.s_rdata[32*i +: 32] = $urandom;
                end
            end
        end
    end

    task automatic do_txn(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                          input int lat, input logic [31:0] rdata, input bit drop_early,
                          input int hold, input int gap);
        exp_t e;
        int   hit;
        bit   seen;
        hit         = ref_decode(addr);
        e.chk_rdata = 1'b0;
        e.rdata     = rdata;
        e.error     = 1'b0;
        if (hit < 0) begin
            e.latency = 1;
            e.error   = 1'b1;
        end else if (lat <= TIMEOUT) begin
            e.latency   = lat + 1;
            e.chk_rdata = (wstrb == 4'b0000);
        end else begin
            e.latency = TIMEOUT + 1;
            e.error   = 1'b1;
        end
        if (e.error) begin
            e.rdata        = ERR_WORD;
            e.chk_rdata    = 1'b1;
            model_err_addr = addr;
            if (model_err_count < 255) model_err_count++;
        end
        e.err_addr  = model_err_addr;
        e.err_count = 8'(model_err_count);

        cur_sel = '0;
        if (hit >= 0) cur_sel[hit] = 1'b1;
        cur_addr   = addr;
        cur_wdata  = wdata;
        cur_wstrb  = wstrb;
        plan_lat   = lat;
        plan_rdata = rdata;

        e.issue_cyc = cyc;
        sb_q.push_back(e);
        bus.m_addr  = addr;
        bus.m_wdata = wdata;
        bus.m_wstrb = wstrb;
        bus.m_valid = 1'b1;

        seen = 1'b0;
        for (int t = 0; t < TIMEOUT + 20 && !seen; t++) begin
            @(negedge clk);
            if (drop_early) bus.m_valid = 1'b0;
            if (bus.m_ready === 1'b1) seen = 1'b1;
        end
        check("m_ready_arrived", 32'(seen), 32'd1);
        // Holding valid through the response and the following idle cycle must not start a new access.
        repeat (hold) @(negedge clk);
        bus.m_valid = 1'b0;
        repeat (2 + gap) @(negedge clk);
    endtask

    task automatic reset_mid_access();
        cur_sel     = 2'b01;
        cur_addr    = 32'h0000_0040;
        cur_wdata   = 32'h0;
        cur_wstrb   = 4'b0000;
        plan_lat    = NEVER;
        bus.m_addr  = 32'h0000_0040;
        bus.m_wdata = 32'h0;
        bus.m_wstrb = 4'b0000;
        bus.m_valid = 1'b1;
        repeat (6) @(negedge clk);
        check("pre_rst_s_sel", 32'(bus.s_sel), 32'h1);
        reset = 1'b1;
        #1;
        check("rstmid_s_sel", 32'(bus.s_sel), 32'd0);
        check("rstmid_m_ready", 32'(bus.m_ready), 32'd0);
        check("rstmid_err_count", 32'(err_count), 32'd0);
        check("rstmid_err_addr", err_addr, 32'd0);
        sb_q.delete();
        model_err_count = 0;
        model_err_addr  = '0;
        bus.m_valid     = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [31:0] a;
        logic [3:0]  ws;
        int          lat;
        int          kind;

        bus.m_valid = 1'b0;
        bus.m_addr  = '0;
        bus.m_wdata = '0;
        bus.m_wstrb = '0;
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_m_ready", 32'(bus.m_ready), 32'd0);
        check("rst_m_rdata", bus.m_rdata, 32'd0);
        check("rst_m_error", 32'(bus.m_error), 32'd0);
        check("rst_s_sel", 32'(bus.s_sel), 32'd0);
        check("rst_s_addr", bus.s_addr, 32'd0);
        check("rst_s_wdata", bus.s_wdata, 32'd0);
        check("rst_s_wstrb", 32'(bus.s_wstrb), 32'd0);
        check("rst_err_addr", err_addr, 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        do_txn(32'h0000_0100, 32'h0, 4'b0000, 1, 32'h1234_5678, 1'b0, 0, 0);
        do_txn(32'h8000_0000, 32'h0000_003F, 4'b0001, 1, 32'h5555_AAAA, 1'b0, 0, 0);
        do_txn(32'h4000_0000, 32'h0, 4'b0000, 1, 32'h0, 1'b0, 0, 0);
        do_txn(32'h0000_1000, 32'h0, 4'b0000, NEVER, 32'h0, 1'b0, 0, 0);
        do_txn(32'h0000_1004, 32'h0, 4'b0000, TIMEOUT, 32'hCAFE_F00D, 1'b0, 2, 0);
        do_txn(32'h0000_0008, 32'h0, 4'b0000, 3, 32'h0BAD_F00D, 1'b1, 0, 0);
        for (int i = 0; i < 4; i++) do_txn(edge_addr[i], 32'h0, 4'b0000, 2, 32'h1000_0000 + i, 1'b0, 2, 0);

        reset_mid_access();
        do_txn(32'h0000_0200, 32'h0, 4'b0000, 2, 32'h89AB_CDEF, 1'b0, 0, 0);

        for (int k = 0; k < 150; k++) begin
            kind = $urandom_range(0, 3);
            case (kind)
                0:       a = $urandom & 32'h0000_1FFF;
                1:       a = 32'h8000_0000;
                2:       a = $urandom;
                default: a = edge_addr[$urandom_range(0, 3)];
            endcase
            ws  = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom);
            lat = ($urandom_range(0, 9) == 0) ? $urandom_range(5, 20) : $urandom_range(1, 4);
            do_txn(a, $urandom, ws, lat, $urandom, ($urandom_range(0, 7) == 0),
                   $urandom_range(0, 2), $urandom_range(0, 2));
        end

        for (int k = 0; k < 256; k++) begin
            do_txn(32'h4000_0000 + 32'(k * 4), 32'h0, 4'b0000, 1, 32'h0, 1'b0, 0, 0);
        end

        repeat (4) @(negedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end
endmodule
